ptr_ctrl: RTL and testbench
===========================

# ptr_ctrl

Per-domain pointer controller for the asynchronous FIFO. One instance runs in the write domain and one in the read domain, directly upstream of `flag`. Each instance:
- advances the local binary/Gray pointer on accepted requests;
- synchronizes the remote Gray pointer into the local clock;
- supplies both pointers to `flag`;
- derives a fill level and an almost-flag;
- gates requests against both the registered `flag` output and its own level, which closes the one-cycle lag of `flag`.

## Interface
- `SIDE`, 0 — 0: read side (pop, limit = empty); 1: write side (push, limit = full).
- `ADDR_WIDTH`, 8 — pointer width including wrap bit; FIFO depth DEPTH = 2^(ADDR_WIDTH-1).
- `SYNC_STAGES`, 2 — flop stages on the remote Gray pointer; legal range ≥2.
- `ALMOST_TH`, 2 — almost threshold in entries.

Ports:
- `clk` in 1 — clock of this domain.
- `rst` in 1 — reset; one clock; reset is asynchronous and active-high.
- `req` in 1 — push (SIDE=1) or pop (SIDE=0) request.
- `flag_in` in 1 — full (SIDE=1) or empty (SIDE=0) from `flag`.
- `remote_gray` in ADDR_WIDTH — other domain's `ptr_gray`; asynchronous to `clk`.
- `accept` out 1 — combinational; request taken this cycle.
- `ptr_bin` out ADDR_WIDTH — local binary pointer, registered.
- `ptr_gray` out ADDR_WIDTH — local Gray pointer, registered; goes to `flag` and to the other domain.
- `mem_addr` out ADDR_WIDTH-1 — `ptr_bin[ADDR_WIDTH-2:0]`; RAM address.
- `remote_gray_sync` out ADDR_WIDTH — last synchronizer stage; goes to `flag`.
- `level` out ADDR_WIDTH — entries in FIFO as seen locally, range 0..DEPTH.
- `almost` out 1 — registered almost-full (SIDE=1) or almost-empty (SIDE=0).

## Operation
- **Limit:**
  - SIDE=1: `limit = (level == DEPTH)`.
  - SIDE=0: `limit = (level == 0)`.
- **Accept:** `accept = req & ~flag_in & ~limit & ~rst`.
- **Pointer advance:** on accept, `bin_next = ptr_bin + 1`, mod 2^ADDR_WIDTH. Otherwise the pointer holds.
- **Gray encoding:** `ptr_gray` is registered from `bin_next ^ (bin_next >> 1)`. Gray is never decoded from combinational logic before crossing. Exactly one bit changes per advance, including at wrap (all-ones binary → 0).
- **Remote path:**
  - `remote_gray` passes through SYNC_STAGES flops; the last stage is `remote_gray_sync`.
  - One further register holds `remote_bin = gray2bin(remote_gray_sync)`.
- **Level:** combinational from registers, ADDR_WIDTH-bit modular subtraction.
  - SIDE=1: `level = ptr_bin - remote_bin`.
  - SIDE=0: `level = remote_bin - ptr_bin`.
- **Level bounds:** by construction, level never exceeds DEPTH. Decrements caused by remote movement are pessimistic only (stale remote ⇒ FIFO looks fuller for a write, emptier for a read).
- **Almost:**
  - SIDE=1: `almost <= (level >= DEPTH - ALMOST_TH)`.
  - SIDE=0: `almost <= (level <= ALMOST_TH)`.
- **Simultaneous events:** `req` and a remote change in the same cycle are independent. Accept uses the current-cycle `level`; the remote change appears later.
- **Reset:** asserting `rst` at any time, including mid-burst, immediately clears every flop to 0. While `rst` is high, `accept` = 0. Release is synchronous to the next `clk` edge; the first accept is possible in the first cycle after release.

## Timing
- **Reset values:** `ptr_bin`, `ptr_gray`, `mem_addr`, `remote_gray_sync`, `level`, `almost` = 0. After reset release, `level` = 0 on both sides, so SIDE=0 starts blocked and SIDE=1 starts open.
- **Local pointer:** `accept` in cycle n ⇒ `ptr_bin`/`ptr_gray`/`mem_addr` updated at edge n+1; `level` reflects it in cycle n+1.
- **Remote pointer:** a change on `remote_gray` sampled at edge k appears on:
  - `remote_gray_sync` after SYNC_STAGES edges;
  - `level` after SYNC_STAGES+1 edges;
  - `almost` after SYNC_STAGES+2 edges.
- **Back-to-back:** one accept per cycle with no bubble.
- **Full/empty gating:** the accept at the final slot blocks the very next cycle via `limit`, independent of `flag_in`.

## Structure
- Package `fifo_pkg` holds:
  - constants `SIDE_RD = 0`, `SIDE_WR = 1`;
  - functions `bin2gray` and `gray2bin`, parameterized by width through the argument width.
- Sub-module `sync_bus` (`WIDTH`, `STAGES`): a plain flop chain with async active-high reset to 0. It is instantiated once for `remote_gray`.
- The limit/level/almost logic stays in `ptr_ctrl`.

## Test plan
Configuration for all scenarios: ADDR_WIDTH=4, DEPTH=8, SYNC_STAGES=2, ALMOST_TH=2.
1. **Reset:** `rst`=1 with `req`=1 → `accept`=0 and all outputs 0. Release → SIDE=1 `accept`=1 next cycle; SIDE=0 `accept`=0.
2. **Write fill:** SIDE=1, `remote_gray`=0, `flag_in`=0, 9 consecutive pushes → first 8 accepted, `ptr_bin`=8, `ptr_gray`=4'b1100, `level`=8, 9th `accept`=0. `almost` rises one cycle after `level` reaches 6.
3. **Wrap:** SIDE=1 with `remote_gray` tracking `ptr_gray` (level ≤ 1), 16 pushes → `ptr_bin` returns to 0. Every `ptr_gray` step changes exactly 1 bit, including 4'b1000 → 4'b0000.
4. **Sync latency:** SIDE=0, `remote_gray` steps 0 → 4'b0011 (bin 2) at edge k → `remote_gray_sync`=4'b0011 at k+2, `level`=2 at k+3, `almost`=1 held throughout (level ≤ 2).
5. **Read gating:** SIDE=0 with level 5, `flag_in`=1 and `req`=1 → `accept`=0 and the pointer holds. `flag_in`=0 → 5 pops accepted, 6th refused (`level`=0).
6. **Async reset mid-burst:** SIDE=1, `ptr_bin`=5, `rst` pulsed between clock edges → all outputs 0 before the next edge. Pushes resume from `ptr_bin`=0.

Source files
------------

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared constants and Gray-code helpers for the asynchronous
//               FIFO pointer logic.
//               SIDE_RD / SIDE_WR select the role of a ptr_ctrl instance.
//               bin2gray / gray2bin work on a 32-bit container. Callers
//               zero-extend their narrower pointer into the argument and cast
//               the result back to their own width. Zero upper bits do not
//               disturb either conversion, so one pair of functions serves
//               every pointer width up to 32.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

  localparam int SIDE_RD = 0;
  localparam int SIDE_WR = 1;

  // Width of the container used by the conversion helpers.
  localparam int c_code_w = 32;

  // Gray code: each bit is the XOR of itself and its upper neighbour.
  function automatic logic [c_code_w-1:0] bin2gray(input logic [c_code_w-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Binary from Gray: each bit is the XOR of all Gray bits at and above it.
  function automatic logic [c_code_w-1:0] gray2bin(input logic [c_code_w-1:0] gray);
    logic [c_code_w-1:0] v_bin;
    v_bin[c_code_w-1] = gray[c_code_w-1];
    for (int i = c_code_w - 2; i >= 0; i--) begin
      v_bin[i] = v_bin[i+1] ^ gray[i];
    end
    return v_bin;
  endfunction

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/sync_bus.sv
`default_nettype none
// ============================================================================
// Module      : sync_bus
// Description : Plain multi-flop synchronizer chain for a bus whose value
//               changes by at most one bit at a time (a Gray pointer).
//               Every stage resets asynchronously to zero.
// Ports       : clk  - destination clock
//               rst  - asynchronous active-high reset
//               d    - bus from the foreign clock domain
//               q    - last synchronizer stage
// Revision    : 1.0 - initial release
// ============================================================================
module sync_bus #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Stage 0 is the metastability catcher; the last stage is the only one
  // consumed downstream.
  logic [WIDTH-1:0] r_stage [STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign q = r_stage[STAGES-1];

endmodule : sync_bus
`default_nettype wire

// File: rtl/ptr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ptr_ctrl
// Description : Per-domain pointer controller of the asynchronous FIFO.
//               Advances the local binary/Gray pointer on accepted requests,
//               brings the remote Gray pointer into the local clock, derives
//               a local fill level and a registered almost flag, and gates
//               requests against both the external full/empty flag and its
//               own level.
//               SIDE = SIDE_WR: push side, limit is full.
//               SIDE = SIDE_RD: pop side, limit is empty.
// Ports       : clk              - clock of this domain
//               rst              - asynchronous active-high reset
//               req              - push (write side) / pop (read side) request
//               flag_in          - full (write side) / empty (read side)
//               remote_gray      - other domain's Gray pointer (asynchronous)
//               accept           - request taken this cycle (combinational)
//               ptr_bin          - local binary pointer, registered
//               ptr_gray         - local Gray pointer, registered
//               mem_addr         - RAM address (pointer without wrap bit)
//               remote_gray_sync - synchronized remote Gray pointer
//               level            - entries in the FIFO as seen locally
//               almost           - registered almost-full / almost-empty
// Revision    : 1.0 - initial release
// ============================================================================
module ptr_ctrl
  import fifo_pkg::*;
#(
  parameter int SIDE        = SIDE_RD,
  parameter int ADDR_WIDTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int ALMOST_TH   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  flag_in,
  input  logic [ADDR_WIDTH-1:0] remote_gray,
  output logic                  accept,
  output logic [ADDR_WIDTH-1:0] ptr_bin,
  output logic [ADDR_WIDTH-1:0] ptr_gray,
  output logic [ADDR_WIDTH-2:0] mem_addr,
  output logic [ADDR_WIDTH-1:0] remote_gray_sync,
  output logic [ADDR_WIDTH-1:0] level,
  output logic                  almost
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int                    c_depth_i  = 2 ** (ADDR_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] c_depth    = ADDR_WIDTH'(c_depth_i);
  localparam logic [ADDR_WIDTH-1:0] c_full_th  = ADDR_WIDTH'(c_depth_i - ALMOST_TH);
  localparam logic [ADDR_WIDTH-1:0] c_empty_th = ADDR_WIDTH'(ALMOST_TH);
  localparam logic [ADDR_WIDTH-1:0] c_one      = ADDR_WIDTH'(1);

  // --------------------------------------------------------------------------
  // Registers and wires
  // --------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] r_ptr_bin;
  logic [ADDR_WIDTH-1:0] r_ptr_gray;
  logic [ADDR_WIDTH-1:0] r_remote_bin;
  logic                  r_almost;

  logic [ADDR_WIDTH-1:0] w_remote_sync;
  logic [ADDR_WIDTH-1:0] w_remote_dec;
  logic [ADDR_WIDTH-1:0] w_bin_next;
  logic [ADDR_WIDTH-1:0] w_gray_next;
  logic [ADDR_WIDTH-1:0] w_level;
  logic                  w_limit;
  logic                  w_almost_next;
  logic                  w_accept;

  // --------------------------------------------------------------------------
  // Remote pointer path: synchronizer chain, then one register holding the
  // decoded binary value. Decoding happens only after the crossing, so the
  // synchronizers only ever see single-bit Gray transitions.
  // --------------------------------------------------------------------------
  sync_bus #(
    .WIDTH  (ADDR_WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync_remote (
    .clk (clk),
    .rst (rst),
    .d   (remote_gray),
    .q   (w_remote_sync)
  );

  assign w_remote_dec = ADDR_WIDTH'(gray2bin(c_code_w'(w_remote_sync)));

  // --------------------------------------------------------------------------
  // Level, limit and almost threshold. The modular subtraction is exact as
  // long as the true distance never exceeds DEPTH, which the accept gating
  // guarantees. A stale remote pointer only ever makes the FIFO look fuller
  // to the writer and emptier to the reader.
  // --------------------------------------------------------------------------
  if (SIDE == SIDE_WR) begin : g_wr_side
    assign w_level       = r_ptr_bin - r_remote_bin;
    assign w_limit       = (w_level == c_depth);
    assign w_almost_next = (w_level >= c_full_th);
  end else begin : g_rd_side
    assign w_level       = r_remote_bin - r_ptr_bin;
    assign w_limit       = (w_level == '0);
    assign w_almost_next = (w_level <= c_empty_th);
  end

  // The local limit closes the one-cycle lag of the registered flag_in: the
  // accept that fills (or drains) the last slot blocks the very next cycle.
  assign w_accept = req & ~flag_in & ~w_limit & ~rst;

  // --------------------------------------------------------------------------
  // Local pointer advance. The Gray value is registered straight from the
  // next binary value so the crossing bus is glitch-free flop output.
  // --------------------------------------------------------------------------
  assign w_bin_next  = w_accept ? (r_ptr_bin + c_one) : r_ptr_bin;
  assign w_gray_next = ADDR_WIDTH'(bin2gray(c_code_w'(w_bin_next)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr_bin    <= '0;
      r_ptr_gray   <= '0;
      r_remote_bin <= '0;
      r_almost     <= 1'b0;
    end else begin
      r_ptr_bin    <= w_bin_next;
      r_ptr_gray   <= w_gray_next;
      r_remote_bin <= w_remote_dec;
      r_almost     <= w_almost_next;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign accept           = w_accept;
  assign ptr_bin          = r_ptr_bin;
  assign ptr_gray         = r_ptr_gray;
  assign mem_addr         = r_ptr_bin[ADDR_WIDTH-2:0];
  assign remote_gray_sync = w_remote_sync;
  assign level            = w_level;
  assign almost           = r_almost;

endmodule : ptr_ctrl
`default_nettype wire

// File: tb/tb_ptr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ptr_ctrl
// Description : Self-checking bench for ptr_ctrl. One read-side and one
//               write-side instance run side by side. The reference model
//               counts accepted requests as plain integers and treats the
//               remote pointer as a value delayed by a fixed number of edges.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ptr_ctrl;
  import fifo_pkg::*;

  localparam int AW    = 4;
  localparam int S     = 2;
  localparam int TH    = 2;
  localparam int DEPTH = 8;

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic [1:0]    req   = '0;   // index 0: read side, index 1: write side
  logic [1:0]    flg   = '0;
  logic [AW-1:0] rg_rd = '0;
  logic [AW-1:0] rg_wr = '0;

  logic          rd_acc, wr_acc, rd_alm, wr_alm;
  logic [AW-1:0] rd_bin, rd_gray, rd_sync, rd_lvl;
  logic [AW-1:0] wr_bin, wr_gray, wr_sync, wr_lvl;
  logic [AW-2:0] rd_addr, wr_addr;

  always #5 clk = ~clk;

  ptr_ctrl #(.SIDE(SIDE_RD), .ADDR_WIDTH(AW), .SYNC_STAGES(S), .ALMOST_TH(TH)) u_rd (
    .clk(clk), .rst(rst), .req(req[0]), .flag_in(flg[0]), .remote_gray(rg_rd),
    .accept(rd_acc), .ptr_bin(rd_bin), .ptr_gray(rd_gray), .mem_addr(rd_addr),
    .remote_gray_sync(rd_sync), .level(rd_lvl), .almost(rd_alm)
  );

  ptr_ctrl #(.SIDE(SIDE_WR), .ADDR_WIDTH(AW), .SYNC_STAGES(S), .ALMOST_TH(TH)) u_wr (
    .clk(clk), .rst(rst), .req(req[1]), .flag_in(flg[1]), .remote_gray(rg_wr),
    .accept(wr_acc), .ptr_bin(wr_bin), .ptr_gray(wr_gray), .mem_addr(wr_addr),
    .remote_gray_sync(wr_sync), .level(wr_lvl), .almost(wr_alm)
  );

  // Reference model state
  int loc [2];          // accepted requests since reset
  int rem [2];          // other domain's pointer count, as driven
  int dq  [2][0:S];     // dq[s][k]: remote value sampled k edges ago
  bit alm [2];
  int checks = 0;
  int errors = 0;

  function automatic int gray(input int b);
    return (b ^ (b >> 1)) & 15;
  endfunction

  function automatic int lvl(input int s);
    if (s == 1) return (loc[1] - dq[1][S]) & 15;
    return (dq[0][S] - loc[0]) & 15;
  endfunction

  function automatic bit exp_acc(input int s);
    bit blocked;
    blocked = (s == 1) ? (lvl(1) == DEPTH) : (lvl(0) == 0);
    return req[s] && !flg[s] && !rst && !blocked;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_vals(input int s, input logic acc, input logic [AW-1:0] bin,
                            input logic [AW-1:0] g, input logic [AW-2:0] addr,
                            input logic [AW-1:0] sync, input logic [AW-1:0] lv,
                            input logic al);
    string p;
    p = (s == 1) ? "wr" : "rd";
    chk({p, ".accept"},   32'(acc),  32'(exp_acc(s)));
    chk({p, ".ptr_bin"},  32'(bin),  32'(loc[s] & 15));
    chk({p, ".ptr_gray"}, 32'(g),    32'(gray(loc[s] & 15)));
    chk({p, ".mem_addr"}, 32'(addr), 32'(loc[s] & 7));
    chk({p, ".sync"},     32'(sync), 32'(gray(dq[s][S-1])));
    chk({p, ".level"},    32'(lv),   32'(lvl(s)));
    chk({p, ".almost"},   32'(al),   32'(alm[s]));
  endtask

  task automatic check_all();
    check_vals(0, rd_acc, rd_bin, rd_gray, rd_addr, rd_sync, rd_lvl, rd_alm);
    check_vals(1, wr_acc, wr_bin, wr_gray, wr_addr, wr_sync, wr_lvl, wr_alm);
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      loc[s] = 0;
      rem[s] = 0;
      alm[s] = 1'b0;
      for (int k = 0; k <= S; k++) dq[s][k] = 0;
    end
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic tick();
    bit a [2];
    int l [2];
    rg_rd = 4'(gray(rem[0] & 15));
    rg_wr = 4'(gray(rem[1] & 15));
    #1;
    check_all();
    for (int s = 0; s < 2; s++) begin
      a[s] = exp_acc(s);
      l[s] = lvl(s);
    end
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (a[s]) loc[s]++;
        alm[s] = (s == 1) ? (l[s] >= DEPTH - TH) : (l[s] <= TH);
        for (int k = S; k > 0; k--) dq[s][k] = dq[s][k-1];
        dq[s][0] = rem[s] & 15;
      end
    end
    @(negedge clk);
  endtask

  // Reset raised between clock edges; outputs must clear before the next edge.
  task automatic pulse_reset();
    #2 rst = 1'b1;
    model_reset();
    #1 check_all();
    @(negedge clk);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [AW-1:0] prev;
    model_reset();

    // Reset with requests pending, then release.
    @(negedge clk);
    req = 2'b11;
    tick();
    rst = 1'b0;
    tick();
    req = 2'b00;
    tick();

    // Write fill: 9 pushes with the reader parked at 0.
    pulse_reset();
    req = 2'b10;
    for (int i = 0; i < 9; i++) tick();
    chk("fill.ptr_bin",  32'(wr_bin),  32'd8);
    chk("fill.ptr_gray", 32'(wr_gray), 32'b1100);
    chk("fill.level",    32'(wr_lvl),  32'd8);
    tick();

    // Wrap: the reader tracks the writer, 16 pushes return the pointer to 0.
    pulse_reset();
    req = 2'b10;
    for (int i = 0; i < 16; i++) begin
      rem[1] = loc[1];
      prev = wr_gray;
      tick();
      if (wr_gray !== prev) chk("wrap.gray_1bit", 32'($countones(wr_gray ^ prev)), 32'd1);
    end
    chk("wrap.ptr_bin", 32'(wr_bin), 32'd0);

    // Sync latency on the read side: remote steps to binary 2.
    pulse_reset();
    req = 2'b00;
    tick();
    tick();
    rem[0] = 2;
    for (int i = 0; i < 5; i++) tick();
    chk("sync.gray",  32'(rd_sync), 32'b0011);
    chk("sync.level", 32'(rd_lvl),  32'd2);

    // Read gating: empty flag blocks, then 5 pops drain, the 6th is refused.
    rem[0] = 5;
    for (int i = 0; i < 4; i++) tick();
    req = 2'b01;
    flg = 2'b01;
    tick();
    tick();
    flg = 2'b00;
    for (int i = 0; i < 6; i++) tick();
    chk("drain.ptr_bin", 32'(rd_bin), 32'd5);
    chk("drain.level",   32'(rd_lvl), 32'd0);
    req = 2'b00;

    // Asynchronous reset in the middle of a push burst.
    pulse_reset();
    req = 2'b10;
    for (int i = 0; i < 5; i++) tick();
    chk("burst.ptr_bin", 32'(wr_bin), 32'd5);
    pulse_reset();
    for (int i = 0; i < 3; i++) tick();
    chk("resume.ptr_bin", 32'(wr_bin), 32'd3);

    // Randomized traffic on both sides with plausible remote pointers.
    for (int i = 0; i < 400; i++) begin
      req    = 2'($urandom);
      flg[0] = ($urandom % 8) == 0;
      flg[1] = ($urandom % 8) == 0;
      if (($urandom % 2) == 1 && rem[0] < loc[0] + DEPTH) rem[0]++;
      if (($urandom % 2) == 1 && rem[1] < loc[1]) rem[1]++;
      if (($urandom % 97) == 0) pulse_reset();
      else tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_ptr_ctrl
`default_nettype wire
